operand_stage: RTL

OPERAND_STAGE -- requirements
Module: operand_stage

---
 rtl/operand_stage_pkg.sv | 21 ++
 rtl/operand_stage_regfile_np.sv | 48 ++++
 rtl/operand_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/operand_stage_pkg.sv
// Shared CPU definitions for the operand-read stage: default datapath
// geometry, the payload width and the stall counter helper.
package operand_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NFWD_DEF = 3;
    localparam int PW_DEF   = 64;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // Increment the stall counter, holding at the maximum instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == STALL_MAX) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/operand_stage_regfile_np.sv
// Architectural register file: NREG x XLEN, two combinational read ports,
// one write port. A read of the address being written in the same cycle
// returns the incoming write data. Register 0 is hardwired to zero and is
// never written.
module regfile_np
    import operand_stage_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic [AW-1:0]   raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREG];

    // Read with r0 forced to zero and a same-cycle write bypassed through.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        if (addr == {AW{1'b0}}) begin
            return {XLEN{1'b0}};
        end else if (we_i && (waddr_i == addr)) begin
            return wdata_i;
        end else begin
            return regs_q[addr];
        end
    endfunction

    // Storage update: contents are deliberately not reset; r0 is never written.
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != {AW{1'b0}})) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Both read ports resolved every cycle.
    always_comb begin
        rdata1_o = read_port(raddr1_i);
        rdata2_o = read_port(raddr2_i);
    end

endmodule

// File: rtl/operand_stage.sv
// Operand-read pipeline stage. Holds one instruction, resolves its two
// source operands from the forwarding network (nearest stage first) or the
// register file, and stalls while the winning forward source is not final.
// Operands are re-resolved every cycle so a stalled instruction picks up
// late data the moment it becomes ready.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NFWD = NFWD_DEF,
    parameter  int PW   = PW_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    // upstream handshake
    input  logic                 in_valid,
    output logic                 in_allowin,
    input  logic [PW-1:0]        in_payload,
    input  logic [AW-1:0]        in_src1,
    input  logic [AW-1:0]        in_src2,
    input  logic                 in_use1,
    input  logic                 in_use2,
    // downstream handshake
    output logic                 out_valid,
    input  logic                 out_allowin,
    output logic [PW-1:0]        out_payload,
    output logic [XLEN-1:0]      out_src1_val,
    output logic [XLEN-1:0]      out_src2_val,
    // forwarding network, index 0 is the youngest stage
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*AW-1:0]   fwd_dest,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [NFWD-1:0]      fwd_ready,
    // register file write port
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    // control
    input  logic                 flush,
    output logic [15:0]          stall_cnt
);

    // Held instruction
    logic            valid_q, valid_d;
    logic [PW-1:0]   payload_q;
    logic [AW-1:0]   src1_q, src2_q;
    logic            use1_q, use2_q;
    logic [15:0]     stall_cnt_q, stall_cnt_d;

    // Operand resolution
    logic [XLEN-1:0] rf_rdata1_s, rf_rdata2_s;
    logic [XLEN-1:0] src1_val_s, src2_val_s;
    logic            src1_blk_s, src2_blk_s;
    logic            ready_go_s;
    logic            load_s;

    regfile_np #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .raddr1_i (src1_q),
        .rdata1_o (rf_rdata1_s),
        .raddr2_i (src2_q),
        .rdata2_o (rf_rdata2_s),
        .we_i     (wb_we),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    // Pick the operand for one source: the lowest-index matching forward
    // stage wins and older stages are ignored even when the winner is not
    // ready yet. r0 never matches and always reads zero.
    function automatic void resolve(
        input  logic [AW-1:0]   src,
        input  logic [XLEN-1:0] rf_val,
        output logic [XLEN-1:0] val,
        output logic            blocked
    );
        logic hit;
        hit     = 1'b0;
        blocked = 1'b0;
        val     = rf_val;
        for (int k = 0; k < NFWD; k++) begin
            if (!hit && fwd_valid[k] && (fwd_dest[k*AW +: AW] == src)) begin
                hit     = 1'b1;
                val     = fwd_data[k*XLEN +: XLEN];
                blocked = !fwd_ready[k];
            end else begin
                hit     = hit;
            end
        end
        if (src == {AW{1'b0}}) begin
            val     = {XLEN{1'b0}};
            blocked = 1'b0;
        end else begin
            val     = val;
        end
    endfunction

    // Resolve both operands and derive the go / handshake signals.
    always_comb begin
        src1_val_s = {XLEN{1'b0}};
        src2_val_s = {XLEN{1'b0}};
        src1_blk_s = 1'b0;
        src2_blk_s = 1'b0;
        resolve(src1_q, rf_rdata1_s, src1_val_s, src1_blk_s);
        resolve(src2_q, rf_rdata2_s, src2_val_s, src2_blk_s);
        ready_go_s = !((use1_q && src1_blk_s) || (use2_q && src2_blk_s));
        in_allowin = !valid_q || (ready_go_s && out_allowin);
        out_valid  = valid_q && ready_go_s;
        load_s     = in_valid && in_allowin && !flush;
    end

    // Next-state for the valid bit and the stall counter; flush beats a load.
    always_comb begin
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_allowin) begin
            valid_d = in_valid;
        end else begin
            valid_d = valid_q;
        end
        if (valid_q && !ready_go_s && !flush) begin
            stall_cnt_d = sat_inc16(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Instruction fields, captured on acceptance; not reset.
    always_ff @(posedge clk) begin
        if (load_s) begin
            payload_q <= in_payload;
            src1_q    <= in_src1;
            src2_q    <= in_src2;
            use1_q    <= in_use1;
            use2_q    <= in_use2;
        end
    end

    assign out_payload  = payload_q;
    assign out_src1_val = src1_val_s;
    assign out_src2_val = src2_val_s;
    assign stall_cnt    = stall_cnt_q;

endmodule
